c432_key_loader: RTL and testbench

//  Serial key-load controller sitting directly upstream of the MUX2-locked c432 netlist.

---
 rtl/c432_key_loader.sv | 114 +++++++++++
 tb/tb_c432_key_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/c432_key_loader.sv
// Serial key-load controller feeding the MUX2-locked c432 netlist.
// A key frame is shifted in LSB first and passed to key_out only after even parity checks.
module c432_key_loader #(
    parameter int KEY_W = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_locked,
    output logic             key_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        CHECK  = 3'd2,
        LOCKED = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [KEY_W-1:0]   shadow_reg, shadow_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               par_reg, par_next;
    logic [KEY_W-1:0]   key_out_reg, key_out_next;
    logic               key_locked_reg, key_locked_next;
    logic               key_err_reg, key_err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            shadow_reg     <= '0;
            cnt_reg        <= '0;
            par_reg        <= 1'b0;
            key_out_reg    <= '0;
            key_locked_reg <= 1'b0;
            key_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shadow_reg     <= shadow_next;
            cnt_reg        <= cnt_next;
            par_reg        <= par_next;
            key_out_reg    <= key_out_next;
            key_locked_reg <= key_locked_next;
            key_err_reg    <= key_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shadow_next     = shadow_reg;
        cnt_next        = cnt_reg;
        par_next        = par_reg;
        key_out_next    = key_out_reg;
        key_locked_next = key_locked_reg;
        key_err_next    = key_err_reg;

        case (state_reg)
            SHIFT: begin
                // A restart wins over a bit presented on the same edge.
                if (load_start) begin
                    cnt_next    = '0;
                    shadow_next = '0;
                end else if (key_valid) begin
                    if (cnt_reg == CNT_W'(KEY_W)) begin
                        par_next   = key_bit;
                        state_next = CHECK;
                    end else begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (cnt_reg == CNT_W'(i)) shadow_next[i] = key_bit;
                        end
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            CHECK: begin
                if ((^shadow_reg ^ par_reg) == 1'b0) begin
                    key_out_next    = shadow_reg;
                    key_locked_next = 1'b1;
                    key_err_next    = 1'b0;
                    state_next      = LOCKED;
                end else begin
                    key_out_next    = '0;
                    key_locked_next = 1'b0;
                    key_err_next    = 1'b1;
                    state_next      = ERROR;
                end
            end
            IDLE, LOCKED, ERROR: begin
                // The previously verified key stays on the bus while a new frame loads.
                if (load_start) begin
                    cnt_next     = '0;
                    shadow_next  = '0;
                    key_err_next = 1'b0;
                    state_next   = SHIFT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign key_ready  = (state_reg == SHIFT);
    assign key_out    = key_out_reg;
    assign key_locked = key_locked_reg;
    assign key_err    = key_err_reg;

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed and randomized checks of c432_key_loader against a frame-level reference model.
module tb_c432_key_loader;

    localparam int KEY_W = 2;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_start;
    logic             key_valid;
    logic             key_bit;
    logic             key_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_locked;
    logic             key_err;

    int tests = 0;
    int fails = 0;

    // Reference model: accepted bits of the current frame plus the visible outputs.
    bit               q[$];
    logic [KEY_W-1:0] m_key;
    logic             m_locked;
    logic             m_err;

    c432_key_loader #(.KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .key_locked (key_locked),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_key_out"}, 32'(key_out), 32'(m_key));
        check({tag, "_locked"}, 32'(key_locked), 32'(m_locked));
        check({tag, "_err"}, 32'(key_err), 32'(m_err));
    endtask

    task automatic do_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        q.delete();
        m_err = 1'b0;
        check("load_ready", 32'(key_ready), 32'd1);
        check_outputs("load");
    endtask

    task automatic load_with_bit(input bit b);
        load_start = 1'b1;
        key_valid  = 1'b1;
        key_bit    = b;
        step();
        load_start = 1'b0;
        key_valid  = 1'b0;
        q.delete();
        m_err = 1'b0;
        check("restart_ready", 32'(key_ready), 32'd1);
    endtask

    task automatic send_bit(input bit b, input int gaps);
        logic [KEY_W-1:0] k;
        int               ones;
        for (int g = 0; g < gaps; g++) begin
            key_valid = 1'b0;
            key_bit   = $urandom_range(0, 1);
            check("gap_ready", 32'(key_ready), 32'd1);
            step();
        end
        key_valid = 1'b1;
        key_bit   = b;
        check("bit_ready", 32'(key_ready), 32'd1);
        check("shift_hold_key", 32'(key_out), 32'(m_key));
        step();
        key_valid = 1'b0;
        q.push_back(b);
        if (q.size() == KEY_W + 1) begin
            // Parity just accepted: outputs must still show the old result for one cycle.
            check("check_ready", 32'(key_ready), 32'd0);
            check_outputs("check_latency");
            k = '0;
            for (int i = 0; i < KEY_W; i++) k[i] = q[i];
            ones = $countones(k) + int'(q[KEY_W]);
            if (ones % 2 == 0) begin
                m_key = k; m_locked = 1'b1; m_err = 1'b0;
            end else begin
                m_key = '0; m_locked = 1'b0; m_err = 1'b1;
            end
            step();
            $display("[TB] frame key=%b par=%0d -> key_out=%b locked=%0d err=%0d",
                     k, q[KEY_W], key_out, key_locked, key_err);
            check("done_ready", 32'(key_ready), 32'd0);
            check_outputs("frame");
            q.delete();
        end
    endtask

    task automatic frame(input bit b0, input bit b1, input bit p, input int gaps);
        send_bit(b0, gaps);
        send_bit(b1, gaps);
        send_bit(p, gaps);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
        m_key = '0; m_locked = 1'b0; m_err = 1'b0;
        #1;
        check("reset_ready", 32'(key_ready), 32'd0);
        check_outputs("reset");
        step();
        rst = 1'b0;
        // Bits presented in IDLE are ignored.
        key_valid = 1'b1; key_bit = 1'b1;
        step(); step();
        key_valid = 1'b0;
        check("idle_ready", 32'(key_ready), 32'd0);
        check_outputs("idle");

        // 1. back-to-back frame 0,1,par=1 -> 2'b10
        do_load();
        frame(1'b0, 1'b1, 1'b1, 0);
        check("t1_key", 32'(key_out), 32'h2);

        // Bits while LOCKED are ignored.
        key_valid = 1'b1; key_bit = 1'b1;
        step(); step();
        key_valid = 1'b0;
        check("locked_ready", 32'(key_ready), 32'd0);
        check_outputs("locked_idle");

        // 2. parity failure, then load_start clears key_err
        do_load();
        frame(1'b1, 1'b1, 1'b1, 0);
        check("t2_err", 32'(key_err), 32'd1);
        step();
        check("err_ready", 32'(key_ready), 32'd0);
        check_outputs("error_hold");
        do_load();
        check("t2_err_clear", 32'(key_err), 32'd0);

        // 3. frame with 3-cycle gaps -> 2'b01
        frame(1'b1, 1'b0, 1'b1, 3);
        check("t3_key", 32'(key_out), 32'h1);

        // 4. locked 10, reload 11, then a bad reload clears the bus
        do_load();
        frame(1'b0, 1'b1, 1'b1, 0);
        do_load();
        frame(1'b1, 1'b1, 1'b0, 1);
        check("t4_key", 32'(key_out), 32'h3);
        do_load();
        frame(1'b0, 1'b1, 1'b0, 0);
        check("t4_err", 32'(key_err), 32'd1);

        // 5. asynchronous reset mid-frame
        do_load();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_key = '0; m_locked = 1'b0; m_err = 1'b0;
        check("t5_async_ready", 32'(key_ready), 32'd0);
        check_outputs("t5_async");
        #1;
        rst = 1'b0;
        step();
        do_load();
        frame(1'b1, 1'b1, 1'b0, 0);
        check("t5_key", 32'(key_out), 32'h3);

        // 6. restart coincident with a valid bit discards everything
        do_load();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        load_with_bit(1'b1);
        frame(1'b0, 1'b1, 1'b1, 0);
        check("t6_key", 32'(key_out), 32'h2);

        // Randomized frames with gaps and occasional mid-frame restarts.
        for (int n = 0; n < 30; n++) begin
            do_load();
            if ($urandom_range(0, 2) == 0) begin
                int partial = $urandom_range(1, KEY_W);
                for (int j = 0; j < partial; j++)
                    send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
                if ($urandom_range(0, 1) == 0) load_with_bit(1'($urandom_range(0, 1)));
                else do_load();
            end
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
            check_outputs("rand_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
